// File: rtl/fetch_stage.sv
// Instruction-fetch stage with integrated IF/ID register: owns the PC, runs the
// req/ack instruction bus, and handles delay-slot redirects, exceptions and eret.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter logic [31:0] EXC_PC   = 32'h0000_4180,
   parameter logic [31:0] IM_BASE  = 32'h0000_3000,
   parameter int          IM_WORDS = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall_d,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        br_in_d,
   input  logic        exc_req,
   input  logic        eret_req,
   input  logic [31:0] epc_in,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        d_valid,
   output logic [31:0] d_instr,
   output logic [31:0] d_pc,
   output logic [31:0] d_pc8,
   output logic        d_bd,
   output logic [4:0]  d_exccode
);

   typedef enum logic [1:0] {
      ST_REQ = 2'd0,
      ST_BUF = 2'd1,
      ST_ERR = 2'd2
   } state_t;

   localparam logic [32:0] IM_LIMIT = {1'b0, IM_BASE} + (33'(IM_WORDS) * 33'd4);
   localparam logic [4:0]  EXC_NONE = 5'd0;
   localparam logic [4:0]  EXC_ADEL = 5'd4;

   state_t      state_r;
   logic [31:0] pc_r;
   logic [31:0] addr_r;
   logic [31:0] pend_pc_r;
   logic        pend_valid_r;
   logic        discard_r;
   logic [31:0] buf_word_r;
   logic        buf_err_r;

   logic        fetch_done_s;
   logic [31:0] fetch_word_s;
   logic        fetch_err_s;
   logic        deliver_s;
   logic [31:0] seq_pc_s;
   logic [31:0] flush_pc_s;

   // Word-aligned and inside the instruction memory window (33-bit limit avoids wrap).
   function automatic logic pc_legal(input logic [31:0] a);
      pc_legal = (a[1:0] == 2'b00) && (a >= IM_BASE) && ({1'b0, a} < IM_LIMIT);
   endfunction

   function automatic state_t fetch_state(input logic [31:0] a);
      fetch_state = pc_legal(a) ? ST_REQ : ST_ERR;
   endfunction

   // The request is decoded from the state register and suppressed while reset is held.
   assign imem_req  = (state_r == ST_REQ) && !reset;
   assign imem_addr = addr_r;

   // Fetch completion, candidate word, and next sequential / flush PC selection.
   always_comb begin
      fetch_done_s = 1'b0;
      fetch_word_s = 32'd0;
      fetch_err_s  = 1'b0;
      case (state_r)
         ST_REQ: begin
            fetch_done_s = imem_ack;
            fetch_word_s = imem_rdata;
            fetch_err_s  = 1'b0;
         end
         ST_BUF: begin
            fetch_done_s = ~stall_d;
            fetch_word_s = buf_word_r;
            fetch_err_s  = buf_err_r;
         end
         ST_ERR: begin
            fetch_done_s = 1'b1;
            fetch_word_s = 32'd0;
            fetch_err_s  = 1'b1;
         end
         default: begin
            fetch_done_s = 1'b0;
            fetch_word_s = 32'd0;
            fetch_err_s  = 1'b0;
         end
      endcase

      deliver_s = fetch_done_s & ~discard_r & ~stall_d;

      // A redirect arriving on the delay-slot delivery edge steers the PC directly.
      if (redirect_valid) begin
         seq_pc_s = redirect_pc;
      end else if (pend_valid_r) begin
         seq_pc_s = pend_pc_r;
      end else begin
         seq_pc_s = pc_r + 32'd4;
      end

      if (exc_req) begin
         flush_pc_s = EXC_PC;
      end else begin
         flush_pc_s = epc_in;
      end
   end

   // Fetch FSM, PC/redirect bookkeeping and the IF/ID pipeline register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r      <= ST_REQ;
         pc_r         <= RESET_PC;
         addr_r       <= RESET_PC;
         pend_pc_r    <= 32'd0;
         pend_valid_r <= 1'b0;
         discard_r    <= 1'b0;
         buf_word_r   <= 32'd0;
         buf_err_r    <= 1'b0;
         d_valid      <= 1'b0;
         d_instr      <= 32'd0;
         d_pc         <= 32'd0;
         d_pc8        <= 32'd8;
         d_bd         <= 1'b0;
         d_exccode    <= EXC_NONE;
      end else if (exc_req || eret_req) begin
         d_valid      <= 1'b0;
         d_instr      <= 32'd0;
         d_bd         <= 1'b0;
         d_exccode    <= EXC_NONE;
         pc_r         <= flush_pc_s;
         pend_valid_r <= 1'b0;
         // An issued request cannot be retracted: hold its address and drop the reply.
         if ((state_r == ST_REQ) && !imem_ack) begin
            discard_r <= 1'b1;
         end else begin
            discard_r <= 1'b0;
            addr_r    <= flush_pc_s;
            state_r   <= fetch_state(flush_pc_s);
         end
      end else begin
         if (deliver_s) begin
            d_valid   <= 1'b1;
            d_instr   <= fetch_word_s;
            d_pc      <= pc_r;
            d_pc8     <= pc_r + 32'd8;
            d_bd      <= br_in_d;
            d_exccode <= fetch_err_s ? EXC_ADEL : EXC_NONE;
         end else if (!stall_d) begin
            d_valid   <= 1'b0;
            d_instr   <= 32'd0;
            d_exccode <= EXC_NONE;
         end else begin
            d_valid   <= d_valid;
         end

         if (fetch_done_s && discard_r) begin
            discard_r <= 1'b0;
            addr_r    <= pc_r;
            state_r   <= fetch_state(pc_r);
         end else if (deliver_s) begin
            pc_r      <= seq_pc_s;
            addr_r    <= seq_pc_s;
            state_r   <= fetch_state(seq_pc_s);
         end else if (fetch_done_s) begin
            buf_word_r <= fetch_word_s;
            buf_err_r  <= fetch_err_s;
            state_r    <= ST_BUF;
         end else begin
            state_r    <= state_r;
         end

         if (deliver_s) begin
            pend_valid_r <= 1'b0;
         end else if (redirect_valid) begin
            pend_pc_r    <= redirect_pc;
            pend_valid_r <= 1'b1;
         end else begin
            pend_valid_r <= pend_valid_r;
         end
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: acked words are queued as expected IF/ID
// contents and compared when the stage delivers them.
module tb_fetch_stage;

   logic        clk;
   logic        reset;
   logic        stall_d;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        br_in_d;
   logic        exc_req;
   logic        eret_req;
   logic [31:0] epc_in;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        d_valid;
   logic [31:0] d_instr;
   logic [31:0] d_pc;
   logic [31:0] d_pc8;
   logic        d_bd;
   logic [4:0]  d_exccode;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] pc8;
      logic        bd;
      logic [4:0]  exc;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   fetch_stage dut (
      .clk            (clk),
      .reset          (reset),
      .stall_d        (stall_d),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .br_in_d        (br_in_d),
      .exc_req        (exc_req),
      .eret_req       (eret_req),
      .epc_in         (epc_in),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .d_valid        (d_valid),
      .d_instr        (d_instr),
      .d_pc           (d_pc),
      .d_pc8          (d_pc8),
      .d_bd           (d_bd),
      .d_exccode      (d_exccode)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] wordof(input logic [31:0] a);
      wordof = a ^ 32'hDEAD_0000;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Acknowledge the outstanding request; optionally queue the word as an expected delivery.
   task automatic ack(input logic [31:0] addr, input logic bd, input logic push);
      exp_t e;
      check("imem_req", {31'd0, imem_req}, 32'd1);
      check("imem_addr", imem_addr, addr);
      imem_ack   = 1'b1;
      imem_rdata = wordof(addr);
      if (push) begin
         e.pc    = addr;
         e.instr = wordof(addr);
         e.pc8   = addr + 32'd8;
         e.bd    = bd;
         e.exc   = 5'd0;
         sb_q.push_back(e);
      end
   endtask

   // One clock: pulses drop after the edge, then a fresh delivery is popped and compared.
   task automatic step();
      logic stall_edge;
      exp_t e;
      stall_edge = stall_d;
      @(posedge clk);
      #1;
      imem_ack       = 1'b0;
      redirect_valid = 1'b0;
      exc_req        = 1'b0;
      eret_req       = 1'b0;
      @(negedge clk);
      if (!stall_edge && (d_valid === 1'b1)) begin
         check("sb_has_entry", {31'd0, (sb_q.size() != 0)}, 32'd1);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("d_pc", d_pc, e.pc);
            check("d_instr", d_instr, e.instr);
            check("d_pc8", d_pc8, e.pc8);
            check("d_bd", {31'd0, d_bd}, {31'd0, e.bd});
            check("d_exccode", {27'd0, d_exccode}, {27'd0, e.exc});
         end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req"}, {31'd0, imem_req}, 32'd0);
      check({tag, "_valid"}, {31'd0, d_valid}, 32'd0);
      check({tag, "_instr"}, d_instr, 32'd0);
      check({tag, "_pc"}, d_pc, 32'd0);
      check({tag, "_pc8"}, d_pc8, 32'd8);
      check({tag, "_bd"}, {31'd0, d_bd}, 32'd0);
      check({tag, "_exc"}, {27'd0, d_exccode}, 32'd0);
   endtask

   initial begin
      exp_t e;
      reset = 1'b1; stall_d = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
      br_in_d = 1'b0; exc_req = 1'b0; eret_req = 1'b0; epc_in = 32'd0;
      imem_ack = 1'b0; imem_rdata = 32'd0;

      // Reset values
      @(negedge clk);
      @(negedge clk);
      check_reset_outputs("rst");
      reset = 1'b0;
      #1;

      // 1: sequential fetch, one ack per cycle
      for (int i = 0; i < 4; i++) begin
         ack(32'h0000_3000 + 32'(i) * 32'd4, 1'b0, 1'b1);
         step();
         check("seq_valid", {31'd0, d_valid}, 32'd1);
      end

      // 2: stall while 0x3010 is acked; skid holds it until release
      stall_d = 1'b1;
      ack(32'h0000_3010, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step();
         check("buf_req", {31'd0, imem_req}, 32'd0);
         check("stall_pc", d_pc, 32'h0000_300C);
         check("stall_valid", {31'd0, d_valid}, 32'd1);
      end
      stall_d = 1'b0;
      step();
      check("after_buf_addr", imem_addr, 32'h0000_3014);

      // 3: branch at 0x3020, delay slot delivered with bd, then target
      for (int i = 0; i < 4; i++) begin
         ack(32'h0000_3014 + 32'(i) * 32'd4, 1'b0, 1'b1);
         step();
      end
      redirect_valid = 1'b1; redirect_pc = 32'h0000_3100; br_in_d = 1'b1;
      ack(32'h0000_3024, 1'b1, 1'b1);
      step();
      br_in_d = 1'b0;
      ack(32'h0000_3100, 1'b0, 1'b1);
      step();
      // redirect before the delay slot returns goes through the pending PC
      ack(32'h0000_3104, 1'b0, 1'b1);
      step();
      redirect_valid = 1'b1; redirect_pc = 32'h0000_3200; br_in_d = 1'b1;
      step();
      check("pend_bubble", {31'd0, d_valid}, 32'd0);
      ack(32'h0000_3108, 1'b1, 1'b1);
      step();
      br_in_d = 1'b0;
      redirect_valid = 1'b1; redirect_pc = 32'h0000_3040;
      ack(32'h0000_3200, 1'b0, 1'b1);
      step();

      // 4: exception while a slow fetch of 0x3040 is outstanding
      check("slow_addr", imem_addr, 32'h0000_3040);
      exc_req = 1'b1;
      step();
      check("exc_flush_valid", {31'd0, d_valid}, 32'd0);
      check("exc_hold_req", {31'd0, imem_req}, 32'd1);
      check("exc_hold_addr", imem_addr, 32'h0000_3040);
      step();
      ack(32'h0000_3040, 1'b0, 1'b0);
      step();
      check("discard_valid", {31'd0, d_valid}, 32'd0);
      ack(32'h0000_4180, 1'b0, 1'b1);
      step();

      // 5: eret to a misaligned EPC gives an AdEL nop without a bus request
      eret_req = 1'b1; epc_in = 32'h0000_3002;
      ack(32'h0000_4184, 1'b0, 1'b0);
      step();
      check("err_no_req", {31'd0, imem_req}, 32'd0);
      check("eret_flush_valid", {31'd0, d_valid}, 32'd0);
      e.pc = 32'h0000_3002; e.instr = 32'd0; e.pc8 = 32'h0000_300A; e.bd = 1'b0; e.exc = 5'd4;
      sb_q.push_back(e);
      step();
      check("adel_valid", {31'd0, d_valid}, 32'd1);
      exc_req = 1'b1;
      step();
      check("exc_from_err_addr", imem_addr, 32'h0000_4180);

      // 6: reset asserted mid-request
      ack(32'h0000_4180, 1'b0, 1'b1);
      step();
      reset = 1'b1;
      #1;
      check_reset_outputs("midrst");
      @(negedge clk);
      reset = 1'b0;
      #1;
      ack(32'h0000_3000, 1'b0, 1'b1);
      step();

      check("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
